// File: rtl/comparator_digit_feeder_if.sv
// Digit interface between the parallel operand source, the digit-serial feeder
// and the downstream comparator tree.
interface comparator_digit_feeder_if #(
    parameter int NUM_INPUTS  = 5,
    parameter int DIGIT_WIDTH = 3,
    parameter int NUM_DIGITS  = 4,
    parameter int PIPE_DEPTH  = 3
);
    localparam int WORD_WIDTH = NUM_DIGITS * DIGIT_WIDTH;
    localparam int IDX_W = ($clog2(NUM_DIGITS + PIPE_DEPTH) > 0) ? $clog2(NUM_DIGITS + PIPE_DEPTH) : 1;

    logic                              io_in_valid;
    logic                              io_in_ready;
    logic [NUM_INPUTS*WORD_WIDTH-1:0]  io_in_bits;
    logic                              io_stall;
    logic                              io_start;
    logic [NUM_INPUTS*DIGIT_WIDTH-1:0] io_digits;
    logic [IDX_W-1:0]                  io_digitIndex;
    logic                              io_last;
    logic                              io_done;

    modport master (
        input  io_in_valid, io_in_bits, io_stall,
        output io_in_ready, io_start, io_digits, io_digitIndex, io_last, io_done
    );

    modport slave (
        output io_in_valid, io_in_bits, io_stall,
        input  io_in_ready, io_start, io_digits, io_digitIndex, io_last, io_done
    );
endinterface

// File: rtl/comparator_digit_feeder.sv
// Captures a parallel vector of operands and streams them MSB digit first,
// then holds the start qualifier for PIPE_DEPTH drain cycles and pulses done.
module comparator_digit_feeder #(
    parameter int NUM_INPUTS  = 5,
    parameter int DIGIT_WIDTH = 3,
    parameter int NUM_DIGITS  = 4,
    parameter int PIPE_DEPTH  = 3
) (
    input  logic clock,
    input  logic reset,
    comparator_digit_feeder_if.master bus
);
    localparam int WORD_WIDTH = NUM_DIGITS * DIGIT_WIDTH;
    localparam int TOTAL      = NUM_DIGITS + PIPE_DEPTH;
    localparam int CNT_W      = ($clog2(TOTAL) > 0) ? $clog2(TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WORD_WIDTH-1:0] sreg_q [NUM_INPUTS];

    logic active;
    logic handshake;

    assign active    = (state_q == SHIFT) || (state_q == DRAIN);
    assign handshake = bus.io_in_valid && bus.io_in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) sreg_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        for (int i = 0; i < NUM_INPUTS; i++)
                            sreg_q[i] <= bus.io_in_bits[i*WORD_WIDTH +: WORD_WIDTH];
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A stalled cycle freezes registers so the same digit is re-presented.
                    if (!bus.io_stall) begin
                        for (int i = 0; i < NUM_INPUTS; i++)
                            sreg_q[i] <= sreg_q[i] << DIGIT_WIDTH;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_DIGIT) begin
                            if (PIPE_DEPTH == 0) state_q <= DONE;
                            else                 state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!bus.io_stall) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_DRAIN) state_q <= DONE;
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.io_digits = '0;
        if (state_q == SHIFT) begin
            for (int i = 0; i < NUM_INPUTS; i++)
                bus.io_digits[i*DIGIT_WIDTH +: DIGIT_WIDTH] = sreg_q[i][WORD_WIDTH-1 -: DIGIT_WIDTH];
        end
    end

    // Ready is masked by reset so the source never sees a false acceptance window.
    assign bus.io_in_ready   = (state_q == IDLE) && !reset;
    assign bus.io_start      = active && !bus.io_stall;
    assign bus.io_digitIndex = active ? cnt_q : '0;
    assign bus.io_last       = (state_q == SHIFT) && (cnt_q == LAST_DIGIT);
    assign bus.io_done       = (state_q == DONE);
endmodule

// File: tb/tb_comparator_digit_feeder.sv
// Scoreboard bench for comparator_digit_feeder: a driver predicts the digit
// stream and done timing, a negedge monitor compares what the feeder presents.
module tb_comparator_digit_feeder;
    localparam int NI = 5;
    localparam int DW = 3;
    localparam int ND = 4;
    localparam int PD = 3;
    localparam int WW = ND * DW;
    localparam int IW = 3;
    localparam int BW = NI * WW;

    typedef struct {
        logic [NI*DW-1:0] digits;
        logic [IW-1:0]    idx;
        logic             last;
    } emit_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    emit_t exp_q[$];
    int    done_q[$];

    int          remaining;
    bit          in_done;
    bit          prev_hs;
    bit          prev_stall;
    bit          prev_reset;
    logic [BW-1:0] prev_bits;

    comparator_digit_feeder_if #(.NUM_INPUTS(NI), .DIGIT_WIDTH(DW), .NUM_DIGITS(ND), .PIPE_DEPTH(PD)) bus ();

    comparator_digit_feeder #(.NUM_INPUTS(NI), .DIGIT_WIDTH(DW), .NUM_DIGITS(ND), .PIPE_DEPTH(PD)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream: each operand's digits MSB first, then PD zero drain cycles.
    function automatic void push_txn(input logic [BW-1:0] b);
        emit_t e;
        int    opv;
        for (int k = 0; k < ND + PD; k++) begin
            e.digits = '0;
            for (int i = 0; i < NI; i++) begin
                opv = int'(b[i*WW +: WW]);
                if (k < ND)
                    e.digits[i*DW +: DW] = DW'((opv >> (DW * (ND - 1 - k))) % (1 << DW));
            end
            e.idx  = IW'(k);
            e.last = (k == ND - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic step(input bit v, input logic [BW-1:0] b, input bit s, input bit r);
        bit ready_exp;
        @(posedge clk);
        #1;
        if (prev_reset) begin
            remaining = 0;
            in_done   = 0;
            exp_q.delete();
            done_q.delete();
        end else begin
            in_done = 0;
            if (remaining > 0 && !prev_stall) begin
                remaining--;
                if (remaining == 0) begin
                    in_done = 1;
                    done_q.push_back(cyc);
                end
            end else if (prev_hs) begin
                remaining = ND + PD;
                push_txn(prev_bits);
            end
        end
        bus.io_in_valid = v;
        bus.io_in_bits  = b;
        bus.io_stall    = s;
        rst             = r;
        #1;
        ready_exp = !r && (remaining == 0) && !in_done;
        chk("in_ready", 64'(bus.io_in_ready), 64'(ready_exp));
        prev_hs    = v && ready_exp;
        prev_bits  = b;
        prev_stall = s;
        prev_reset = r;
    endtask

    task automatic send(input logic [BW-1:0] b, input logic [15:0] stall_mask);
        step(1'b1, b, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) step(1'b0, '0, stall_mask[k], 1'b0);
    endtask

    function automatic logic [BW-1:0] rand_bits();
        logic [BW-1:0] b;
        b[31:0]    = $urandom();
        b[BW-1:32] = (BW-32)'($urandom());
        return b;
    endfunction

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (exp_q.size() > 0) begin
                chk("start", 64'(bus.io_start), 64'(!bus.io_stall));
                chk("digits", 64'(bus.io_digits), 64'(exp_q[0].digits));
                chk("digit_index", 64'(bus.io_digitIndex), 64'(exp_q[0].idx));
                chk("last", 64'(bus.io_last), 64'(exp_q[0].last));
                chk("done_early", 64'(bus.io_done), 64'(0));
                if (bus.io_start) void'(exp_q.pop_front());
            end else begin
                chk("idle_start", 64'(bus.io_start), 64'(0));
                chk("idle_digits", 64'(bus.io_digits), 64'(0));
                chk("idle_index", 64'(bus.io_digitIndex), 64'(0));
                chk("idle_last", 64'(bus.io_last), 64'(0));
                if (bus.io_done) begin
                    if (done_q.size() == 0) begin
                        chk("spurious_done", 64'(bus.io_done), 64'(0));
                    end else begin
                        chk("done_cycle", 64'(cyc), 64'(done_q[0]));
                        void'(done_q.pop_front());
                    end
                end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
                    chk("done_missing", 64'(bus.io_done), 64'(1));
                    void'(done_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [BW-1:0] b;
        checks = 0; errors = 0;
        remaining = 0; in_done = 0;
        prev_hs = 0; prev_stall = 0; prev_reset = 1; prev_bits = '0;
        rst = 1'b1;
        bus.io_in_valid = 1'b0;
        bus.io_in_bits  = '0;
        bus.io_stall    = 1'b0;

        // Reset held with traffic present: nothing may be accepted.
        for (int k = 0; k < 3; k++) step(1'b1, rand_bits(), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Single operand 0xABC in lane 0, no stall.
        b = '0;
        b[WW-1:0] = 12'hABC;
        send(b, 16'h0000);

        // Five distinct operands streamed in parallel.
        b = {12'hFFF, 12'hABC, 12'h789, 12'h456, 12'h123};
        send(b, 16'h0000);

        // Stall during the third and fourth cycles of the stream.
        send(b, 16'h000C);

        // Valid held high: recaptures only when the feeder returns to idle.
        for (int k = 0; k < 24; k++) step(1'b1, rand_bits(), 1'($urandom_range(0, 1)), 1'b0);
        for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b0, 1'b0);

        // Reset in the middle of a stream, then a fresh vector.
        step(1'b1, rand_bits(), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        send(rand_bits(), 16'h0000);

        // Random traffic with random stalls and idle gaps.
        for (int t = 0; t < 30; t++) begin
            int gap;
            int tries;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step(1'b0, '0, ($urandom_range(0, 3) == 0), 1'b0);
            tries = 0;
            b = rand_bits();
            step(1'b1, b, ($urandom_range(0, 3) == 0), 1'b0);
            while (!prev_hs && tries < 40) begin
                step(1'b1, b, ($urandom_range(0, 3) == 0), 1'b0);
                tries++;
            end
            if (!prev_hs) chk("accept_timeout", 64'(prev_hs), 64'(1));
        end
        for (int k = 0; k < 20; k++) step(1'b0, '0, 1'b0, 1'b0);

        chk("stream_drained", 64'(exp_q.size()), 64'(0));
        chk("done_drained", 64'(done_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
